// File: rtl/pic_job_scheduler_if.sv
// Job/DMA/datapath handshake bundle for pic_job_scheduler.
// The scheduler is the slave; the surrounding top level, DMA engine and datapath drive the master side.
interface pic_job_scheduler_if #(
    parameter int PIC_W = 4
);
    logic             in_valid;
    logic [PIC_W-1:0] in_pic_no;
    logic             in_mode;
    logic [1:0]       in_ratio_mode;
    logic             flush;
    logic             ready;
    logic             dma_req;
    logic             dma_wr;
    logic [PIC_W-1:0] dma_pic;
    logic             dma_done;
    logic             dp_start;
    logic             dp_mode;
    logic [1:0]       dp_ratio;
    logic             dp_done;
    logic             job_done;
    logic             err;

    modport master (
        output in_valid, in_pic_no, in_mode, in_ratio_mode, flush, dma_done, dp_done,
        input  ready, dma_req, dma_wr, dma_pic, dp_start, dp_mode, dp_ratio, job_done, err
    );

    modport slave (
        input  in_valid, in_pic_no, in_mode, in_ratio_mode, flush, dma_done, dp_done,
        output ready, dma_req, dma_wr, dma_pic, dp_start, dp_mode, dp_ratio, job_done, err
    );
endinterface

// File: rtl/pic_job_scheduler.sv
// Single-slot picture cache controller: hit/miss decision, DMA write-back/fetch sequencing,
// datapath start/wait, flush of a dirty slot, and per-wait-state timeout abort.
module pic_job_scheduler #(
    parameter int PIC_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    pic_job_scheduler_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FETCH, S_RUN} state_t;

    state_t           r_state;
    logic             r_res_valid;
    logic             r_res_dirty;
    logic [PIC_W-1:0] r_res_pic;
    logic [PIC_W-1:0] r_job_pic;
    logic             r_flush_op;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_dma_req;
    logic             r_dma_wr;
    logic [PIC_W-1:0] r_dma_pic;
    logic             r_dp_start;
    logic             r_dp_mode;
    logic [1:0]       r_dp_ratio;
    logic             r_job_done;
    logic             r_err;

    logic w_hit;
    logic w_timeout;
    logic w_dma_ack;
    logic w_dp_ack;

    assign w_hit     = r_res_valid && (r_res_pic == bus.in_pic_no);
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    // A done coinciding with its own request/start pulse is not a real completion.
    assign w_dma_ack = bus.dma_done && !r_dma_req;
    assign w_dp_ack  = bus.dp_done && !r_dp_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_res_dirty <= 1'b0;
            r_res_pic   <= '0;
            r_job_pic   <= '0;
            r_flush_op  <= 1'b0;
            r_wait_cnt  <= '0;
            r_dma_req   <= 1'b0;
            r_dma_wr    <= 1'b0;
            r_dma_pic   <= '0;
            r_dp_start  <= 1'b0;
            r_dp_mode   <= 1'b0;
            r_dp_ratio  <= 2'd0;
            r_job_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_dma_req  <= 1'b0;
            r_dp_start <= 1'b0;
            r_job_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait_cnt <= '0;
                    if (bus.in_valid) begin
                        r_job_pic  <= bus.in_pic_no;
                        r_dp_mode  <= bus.in_mode;
                        r_dp_ratio <= bus.in_ratio_mode;
                        r_flush_op <= 1'b0;
                        if (w_hit) begin
                            r_dp_start <= 1'b1;
                            r_state    <= S_RUN;
                        end else if (r_res_dirty) begin
                            r_dma_req <= 1'b1;
                            r_dma_wr  <= 1'b1;
                            r_dma_pic <= r_res_pic;
                            r_state   <= S_WB;
                        end else begin
                            r_dma_req <= 1'b1;
                            r_dma_wr  <= 1'b0;
                            r_dma_pic <= bus.in_pic_no;
                            r_state   <= S_FETCH;
                        end
                    end else if (bus.flush) begin
                        if (r_res_dirty) begin
                            r_flush_op <= 1'b1;
                            r_dma_req  <= 1'b1;
                            r_dma_wr   <= 1'b1;
                            r_dma_pic  <= r_res_pic;
                            r_state    <= S_WB;
                        end else begin
                            r_job_done <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (w_dma_ack) begin
                        r_res_dirty <= 1'b0;
                        r_wait_cnt  <= '0;
                        if (r_flush_op) begin
                            r_job_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_dma_req <= 1'b1;
                            r_dma_wr  <= 1'b0;
                            r_dma_pic <= r_job_pic;
                            r_state   <= S_FETCH;
                        end
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_res_valid <= 1'b0;
                        r_res_dirty <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_FETCH: begin
                    if (w_dma_ack) begin
                        r_res_valid <= 1'b1;
                        r_res_pic   <= r_job_pic;
                        r_res_dirty <= 1'b0;
                        r_wait_cnt  <= '0;
                        r_dp_start  <= 1'b1;
                        r_state     <= S_RUN;
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_res_valid <= 1'b0;
                        r_res_dirty <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_dp_ack) begin
                        // Exposure with a non-unity ratio rewrites the picture in SRAM.
                        if (r_dp_mode && (r_dp_ratio != 2'd2))
                            r_res_dirty <= 1'b1;
                        r_job_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_res_valid <= 1'b0;
                        r_res_dirty <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready    = (r_state == S_IDLE);
    assign bus.dma_req  = r_dma_req;
    assign bus.dma_wr   = r_dma_wr;
    assign bus.dma_pic  = r_dma_pic;
    assign bus.dp_start = r_dp_start;
    assign bus.dp_mode  = r_dp_mode;
    assign bus.dp_ratio = r_dp_ratio;
    assign bus.job_done = r_job_done;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_pic_job_scheduler.sv
// Bench for pic_job_scheduler: directed scenarios plus random jobs checked against a
// resident-slot model (valid/pic/dirty) that predicts each job's command sequence.
module tb_pic_job_scheduler;
    localparam int PIC_W       = 4;
    localparam int TIMEOUT_CYC = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pic_job_scheduler_if #(.PIC_W(PIC_W)) bus ();

    pic_job_scheduler #(.PIC_W(PIC_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the single resident SRAM slot
    bit               m_valid;
    bit               m_dirty;
    logic [PIC_W-1:0] m_pic;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle lat cycles (nothing may pulse), then deliver one done pulse.
    task automatic wait_then_pulse(input int lat, input bit is_dma);
        repeat (lat) begin
            step();
            n_cmp++;
            if ({bus.dma_req, bus.dp_start, bus.job_done, bus.ready} !== 4'b0000) begin
                n_bad++;
                $display("FAIL wait_quiet: got req/start/done/ready=%b expected 0000",
                         {bus.dma_req, bus.dp_start, bus.job_done, bus.ready});
            end
        end
        if (is_dma) bus.dma_done = 1'b1;
        else        bus.dp_done  = 1'b1;
        step();
        bus.dma_done = 1'b0;
        bus.dp_done  = 1'b0;
    endtask

    task automatic run_job(input logic [PIC_W-1:0] pic, input bit mode, input logic [1:0] ratio,
                           input int dma_lat, input int dp_lat, input bit with_flush);
        bit exp_hit;
        bit exp_wb;
        logic [PIC_W-1:0] victim;
        exp_hit = m_valid && (m_pic == pic);
        exp_wb  = !exp_hit && m_dirty;
        victim  = m_pic;
        $display("job pic=%0d mode=%0d ratio=%0d flush=%0d hit=%0d wb=%0d",
                 pic, mode, ratio, with_flush, exp_hit, exp_wb);
        bus.in_valid = 1'b1; bus.in_pic_no = pic; bus.in_mode = mode;
        bus.in_ratio_mode = ratio; bus.flush = with_flush;
        step();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        n_cmp++;
        if (bus.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL accept_busy: got ready=%b expected 0", bus.ready);
        end
        if (exp_wb) begin
            n_cmp++;
            if ({bus.dma_req, bus.dma_wr, bus.dma_pic, bus.dp_start} !== {1'b1, 1'b1, victim, 1'b0}) begin
                n_bad++;
                $display("FAIL wb_cmd: got req/wr/pic/start=%b/%b/%0d/%b expected 1/1/%0d/0",
                         bus.dma_req, bus.dma_wr, bus.dma_pic, bus.dp_start, victim);
            end
            wait_then_pulse(dma_lat, 1'b1);
        end
        if (!exp_hit) begin
            n_cmp++;
            if ({bus.dma_req, bus.dma_wr, bus.dma_pic, bus.dp_start} !== {1'b1, 1'b0, pic, 1'b0}) begin
                n_bad++;
                $display("FAIL fetch_cmd: got req/wr/pic/start=%b/%b/%0d/%b expected 1/0/%0d/0",
                         bus.dma_req, bus.dma_wr, bus.dma_pic, bus.dp_start, pic);
            end
            wait_then_pulse(dma_lat, 1'b1);
        end
        n_cmp++;
        if ({bus.dp_start, bus.dp_mode, bus.dp_ratio, bus.dma_req} !== {1'b1, mode, ratio, 1'b0}) begin
            n_bad++;
            $display("FAIL dp_start: got start/mode/ratio/req=%b/%b/%0d/%b expected 1/%b/%0d/0",
                     bus.dp_start, bus.dp_mode, bus.dp_ratio, bus.dma_req, mode, ratio);
        end
        wait_then_pulse(dp_lat, 1'b0);
        n_cmp++;
        if ({bus.job_done, bus.ready, bus.dp_start, bus.dma_req} !== 4'b1100) begin
            n_bad++;
            $display("FAIL job_done: got done/ready/start/req=%b expected 1100",
                     {bus.job_done, bus.ready, bus.dp_start, bus.dma_req});
        end
        m_valid = 1'b1;
        m_pic   = pic;
        if (!exp_hit) m_dirty = 1'b0;
        if (mode && ratio != 2'd2) m_dirty = 1'b1;
    endtask

    task automatic do_flush(input int lat);
        $display("flush dirty=%0d pic=%0d", m_dirty, m_pic);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        if (m_dirty) begin
            n_cmp++;
            if ({bus.dma_req, bus.dma_wr, bus.dma_pic, bus.job_done} !== {1'b1, 1'b1, m_pic, 1'b0}) begin
                n_bad++;
                $display("FAIL flush_wb: got req/wr/pic/done=%b/%b/%0d/%b expected 1/1/%0d/0",
                         bus.dma_req, bus.dma_wr, bus.dma_pic, bus.job_done, m_pic);
            end
            wait_then_pulse(lat, 1'b1);
            m_dirty = 1'b0;
        end
        n_cmp++;
        if ({bus.job_done, bus.dma_req, bus.ready} !== 3'b101) begin
            n_bad++;
            $display("FAIL flush_done: got done/req/ready=%b expected 101",
                     {bus.job_done, bus.dma_req, bus.ready});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_pic_no = '0; bus.in_mode = 1'b0; bus.in_ratio_mode = 2'd0;
        bus.flush = 1'b0; bus.dma_done = 1'b0; bus.dp_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        m_valid = 1'b0; m_dirty = 1'b0; m_pic = '0;
        n_cmp++;
        if ({bus.ready, bus.dma_req, bus.dma_wr, bus.dma_pic, bus.dp_start, bus.dp_mode,
             bus.dp_ratio, bus.job_done, bus.err} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got ready=%b req=%b wr=%b pic=%0d start=%b mode=%b ratio=%0d done=%b err=%b expected ready=1 rest 0",
                     bus.ready, bus.dma_req, bus.dma_wr, bus.dma_pic, bus.dp_start, bus.dp_mode,
                     bus.dp_ratio, bus.job_done, bus.err);
        end
        $display("reset applied");
    endtask

    task automatic test_directed();
        run_job(4'd3, 1'b0, 2'd0, 10, 4, 1'b0);   // cold miss
        run_job(4'd3, 1'b0, 2'd0, 3, 2, 1'b0);    // hit
        run_job(4'd3, 1'b1, 2'd0, 3, 2, 1'b0);    // hit, dirties slot
        run_job(4'd7, 1'b1, 2'd1, 5, 3, 1'b0);    // dirty evict of 3, then fetch 7
        do_flush(4);                              // write back 7
        do_flush(4);                              // clean flush
    endtask

    task automatic test_timeout();
        int n;
        $display("timeout job pic=9");
        bus.in_valid = 1'b1; bus.in_pic_no = 4'd9; bus.in_mode = 1'b0; bus.in_ratio_mode = 2'd2;
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({bus.dma_req, bus.dma_wr, bus.dma_pic} !== {1'b1, 1'b0, 4'd9}) begin
            n_bad++;
            $display("FAIL timeout_fetch: got req/wr/pic=%b/%b/%0d expected 1/0/9",
                     bus.dma_req, bus.dma_wr, bus.dma_pic);
        end
        n = 0;
        while (bus.err !== 1'b1 && n < TIMEOUT_CYC + 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (n < TIMEOUT_CYC - 1 || n > TIMEOUT_CYC + 1) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles expected about %0d", n, TIMEOUT_CYC);
        end
        n_cmp++;
        if ({bus.err, bus.ready, bus.job_done, bus.dma_req} !== 4'b1100) begin
            n_bad++;
            $display("FAIL timeout_state: got err/ready/done/req=%b expected 1100",
                     {bus.err, bus.ready, bus.job_done, bus.dma_req});
        end
        m_valid = 1'b0; m_dirty = 1'b0;
        run_job(4'd7, 1'b0, 2'd0, 2, 2, 1'b0);   // slot invalidated -> miss
    endtask

    task automatic test_busy_and_reset();
        $display("busy job pic=5 with in_valid during fetch");
        bus.in_valid = 1'b1; bus.in_pic_no = 4'd5; bus.in_mode = 1'b0; bus.in_ratio_mode = 2'd3;
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({bus.dma_req, bus.dma_wr, bus.dma_pic} !== {1'b1, 1'b0, 4'd5}) begin
            n_bad++;
            $display("FAIL busy_fetch: got req/wr/pic=%b/%b/%0d expected 1/0/5",
                     bus.dma_req, bus.dma_wr, bus.dma_pic);
        end
        bus.in_valid = 1'b1; bus.in_pic_no = 4'd2; bus.in_mode = 1'b1; bus.in_ratio_mode = 2'd0;
        repeat (3) begin
            step();
            n_cmp++;
            if ({bus.dma_req, bus.dp_start, bus.job_done, bus.ready} !== 4'b0000) begin
                n_bad++;
                $display("FAIL busy_ignore: got req/start/done/ready=%b expected 0000",
                         {bus.dma_req, bus.dp_start, bus.job_done, bus.ready});
            end
        end
        bus.in_valid = 1'b0;
        bus.dma_done = 1'b1;
        step();
        bus.dma_done = 1'b0;
        n_cmp++;
        if ({bus.dp_start, bus.dp_mode, bus.dp_ratio} !== {1'b1, 1'b0, 2'd3}) begin
            n_bad++;
            $display("FAIL busy_dp: got start/mode/ratio=%b/%b/%0d expected 1/0/3",
                     bus.dp_start, bus.dp_mode, bus.dp_ratio);
        end
        $display("reset during run");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_valid = 1'b0; m_dirty = 1'b0; m_pic = '0;
        n_cmp++;
        if ({bus.ready, bus.dp_start, bus.job_done, bus.dma_req, bus.err} !== 5'b10000) begin
            n_bad++;
            $display("FAIL run_reset: got ready/start/done/req/err=%b expected 10000",
                     {bus.ready, bus.dp_start, bus.job_done, bus.dma_req, bus.err});
        end
        bus.dp_done = 1'b1;
        step();
        bus.dp_done = 1'b0;
        repeat (2) begin
            n_cmp++;
            if ({bus.job_done, bus.ready} !== 2'b01) begin
                n_bad++;
                $display("FAIL late_done: got done/ready=%b expected 01", {bus.job_done, bus.ready});
            end
            step();
        end
        run_job(4'd5, 1'b0, 2'd0, 2, 2, 1'b0);   // slot cleared by reset -> miss
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                do_flush($urandom_range(1, 6));
            end else begin
                run_job(PIC_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)), $urandom_range(1, 6), $urandom_range(1, 6),
                        r == 2);
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.dma_done = 1'($urandom_range(0, 1));
                bus.dp_done  = 1'($urandom_range(0, 1));
                step();
                bus.dma_done = 1'b0;
                bus.dp_done  = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_busy_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
